// File: rtl/conv_relu_maxpool.sv
// -----------------------------------------------------------------------------
// conv_relu_maxpool
//   Sits directly after the Conv stage. Takes its signed result stream, applies
//   ReLU, then a 2x2 stride-2 max-pool over an IN_W x IN_H map that arrives in
//   raster order. Each pooled value is emitted as a one-cycle pulse with its
//   raster index. The frame's last value also carries an end-of-frame pulse.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   clr        in   1      synchronous frame abort; wins over in_valid
//   in_valid   in   1      din is valid this cycle
//   din        in   DW     Conv result, two's complement
//   out_valid  out  1      one-cycle pulse per pooled value
//   dout       out  DW     pooled value, always >= 0
//   out_idx    out  IDX_W  raster index of the pooled value
//   frame_done out  1      pulses together with the frame's last out_valid
//   busy       out  1      high from the first accepted sample until frame end
// -----------------------------------------------------------------------------
module conv_relu_maxpool #(
    parameter int DW    = 16,
    parameter int IN_W  = 6,
    parameter int IN_H  = 6,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [DW-1:0]    din,
    output logic             out_valid,
    output logic [DW-1:0]    dout,
    output logic [IDX_W-1:0] out_idx,
    output logic             frame_done,
    output logic             busy
);

    localparam int HALF_W = IN_W / 2;
    localparam int NPOOL  = (IN_W / 2) * (IN_H / 2);
    localparam int CW     = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW     = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [CW-1:0]    LAST_COL = CW'(IN_W - 1);
    localparam logic [RW-1:0]    LAST_ROW = RW'(IN_H - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOOL - 1);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [IDX_W-1:0] pool_cnt;
    logic [DW-1:0]    hreg;
    logic [DW-1:0]    lbuf [HALF_W];

    logic             accept;
    logic [DW-1:0]    r;
    logic [DW-1:0]    m;
    logic [DW-1:0]    pooled;
    logic [LB_AW-1:0] lb_idx;

    assign accept = in_valid && !clr;
    assign lb_idx = LB_AW'(col >> 1);

    // After ReLU every value is non-negative, so plain unsigned compares are
    // correct for the max operations below.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        r      = '0;
        m      = '0;
        pooled = '0;
        if (!din[DW-1]) r = din;
        m      = (hreg > r) ? hreg : r;
        pooled = (lbuf[lb_idx] > m) ? lbuf[lb_idx] : m;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            pool_cnt   <= '0;
            hreg       <= '0;
            out_valid  <= 1'b0;
            dout       <= '0;
            out_idx    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            // NOTE: the line buffer is small and must be cleared on reset, so
            // it lives in the reset branch; larger memories would not.
            for (int i = 0; i < HALF_W; i++) lbuf[i] <= '0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (clr) begin
                col      <= '0;
                row      <= '0;
                pool_cnt <= '0;
                hreg     <= '0;
                busy     <= 1'b0;
            end else begin
                if (accept) begin
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end

                    if (!col[0]) begin
                        hreg <= r;
                    end else if (!row[0]) begin
                        lbuf[lb_idx] <= m;
                    end else begin
                        dout       <= pooled;
                        out_valid  <= 1'b1;
                        out_idx    <= pool_cnt;
                        frame_done <= (pool_cnt == LAST_IDX);
                        pool_cnt   <= (pool_cnt == LAST_IDX) ? '0 : pool_cnt + 1'b1;
                    end
                end

                // Setting beats clearing so a frame starting in the previous
                // frame's frame_done cycle keeps busy high without a dip.
                if (accept && col == '0 && row == '0) busy <= 1'b1;
                else if (frame_done)                  busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_relu_maxpool.sv
module tb_conv_relu_maxpool;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [15:0] din;
    logic        out_valid;
    logic [15:0] dout;
    logic [3:0]  out_idx;
    logic        frame_done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] frame_in  [36];
    logic [15:0] frame_exp [9];

    typedef struct {
        logic [15:0] a;   // top-left
        logic [15:0] b;   // top-right
        logic [15:0] c;   // bottom-left
        logic [15:0] d;   // bottom-right
        logic [15:0] exp;
    } win_vec_t;

    win_vec_t vecs [9];

    conv_relu_maxpool #(.DW(16), .IN_W(6), .IN_H(6), .IDX_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .din        (din),
        .out_valid  (out_valid),
        .dout       (dout),
        .out_idx    (out_idx),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic c);
        in_valid = v;
        din      = d;
        clr      = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " out_valid"},  32'(out_valid),  32'd0);
        check({tag, " dout"},       32'(dout),       32'd0);
        check({tag, " out_idx"},    32'(out_idx),    32'd0);
        check({tag, " frame_done"}, 32'(frame_done), 32'd0);
        check({tag, " busy"},       32'(busy),       32'd0);
    endtask

    // Feed sample i of frame_in and check the outputs one cycle later.
    task automatic feed(input int i, input string tag);
        int r, c, k;
        r = i / 6;
        c = i % 6;
        step(1'b1, frame_in[i], 1'b0);
        check({tag, " busy"}, 32'(busy), 32'd1);
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            k = (r / 2) * 3 + c / 2;
            check({tag, " out_valid"},  32'(out_valid),  32'd1);
            check({tag, " dout"},       32'(dout),       32'(frame_exp[k]));
            check({tag, " out_idx"},    32'(out_idx),    32'(k));
            check({tag, " frame_done"}, 32'(frame_done), (k == 8) ? 32'd1 : 32'd0);
        end else begin
            check({tag, " out_valid"},  32'(out_valid),  32'd0);
            check({tag, " frame_done"}, 32'(frame_done), 32'd0);
        end
    endtask

    task automatic run_frame(input int gap, input string tag);
        for (int i = 0; i < 36; i++) begin
            feed(i, tag);
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 16'hDEAD, 1'b0);
                check({tag, " gap out_valid"}, 32'(out_valid), 32'd0);
            end
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 36; i++) frame_in[i] = 16'(i);
        frame_exp = '{16'd7, 16'd9, 16'd11, 16'd19, 16'd21, 16'd23, 16'd31, 16'd33, 16'd35};
    endtask

    task automatic idle_check_busy_low(input string tag);
        step(1'b0, 16'h0, 1'b0);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        // Window table: each record fills one 2x2 window of a single frame.
        vecs[0] = '{16'hFFFB, 16'h0003, 16'hFFFF, 16'hFFFE, 16'h0003}; // -5 and 3 -> 3
        vecs[1] = '{16'hFFF6, 16'hFFF6, 16'hFFF6, 16'hFFF6, 16'h0000}; // all negative
        vecs[2] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0001, 16'h7FFF}; // extremes
        vecs[3] = '{16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005}; // ties
        vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[5] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0004}; // max bottom-right
        vecs[6] = '{16'h0064, 16'h0001, 16'h0001, 16'h0001, 16'h0064}; // max top-left
        vecs[7] = '{16'h0001, 16'h0001, 16'h00C8, 16'h0001, 16'h00C8}; // max bottom-left
        vecs[8] = '{16'h1234, 16'hFFF6, 16'h4000, 16'h3FFF, 16'h4000};

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; din = '0;

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        step(1'b0, 16'h0, 1'b0);

        // Contiguous ramp.
        load_ramp();
        run_frame(0, "ramp");
        idle_check_busy_low("ramp end");

        // Ramp with a gap after every sample.
        run_frame(1, "gaps");
        idle_check_busy_low("gaps end");

        // All negative samples.
        for (int i = 0; i < 36; i++) frame_in[i] = 16'hFFF6;
        for (int k = 0; k < 9; k++) frame_exp[k] = 16'h0000;
        run_frame(0, "neg");
        idle_check_busy_low("neg end");

        // Table-driven windows.
        for (int k = 0; k < 9; k++) begin
            int base;
            base = (k / 3) * 12 + (k % 3) * 2;
            frame_in[base]     = vecs[k].a;
            frame_in[base + 1] = vecs[k].b;
            frame_in[base + 6] = vecs[k].c;
            frame_in[base + 7] = vecs[k].d;
            frame_exp[k]       = vecs[k].exp;
        end
        run_frame(0, "table");
        idle_check_busy_low("table end");

        // Abort: 10 ramp samples, then clr together with a valid sample.
        load_ramp();
        for (int i = 0; i < 10; i++) feed(i, "abort part");
        step(1'b1, 16'd10, 1'b1);
        check("abort clr out_valid", 32'(out_valid), 32'd0);
        check("abort clr busy",      32'(busy),      32'd0);
        step(1'b0, 16'h0, 1'b0);
        check("abort idle out_valid", 32'(out_valid), 32'd0);
        run_frame(0, "abort full");
        idle_check_busy_low("abort end");

        // Back-to-back frames: busy must stay high across the boundary.
        run_frame(0, "b2b f1");
        run_frame(0, "b2b f2");
        idle_check_busy_low("b2b end");

        // Asynchronous reset in the middle of a frame, while out_valid is high.
        for (int i = 0; i < 8; i++) feed(i, "midrst part");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst async");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        check_zero("midrst idle");
        run_frame(0, "after rst");
        idle_check_busy_low("after rst end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
